// File: rtl/grf_hazard_ctrl.sv
// GRF scoreboard: tracks E/M/W writers with Tnew, resolves D-stage
// forwarding and stalls by Tuse/Tnew comparison, counts stall cycles.
module grf_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_rs_tuse,
  input  logic [1:0]       d_rt_tuse,
  input  logic             d_wr_en,
  input  logic [4:0]       d_wr_addr,
  input  logic [1:0]       d_tnew,
  input  logic             d_md_use,
  input  logic             md_busy,
  output logic             stall,
  output logic [1:0]       rs_fwd_sel,
  output logic [1:0]       rt_fwd_sel,
  output logic             rs_late,
  output logic             rt_late,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       e_v, m_v, w_v;
  logic [4:0] e_a, m_a, w_a;
  logic [1:0] e_t, m_t, w_t;
  logic       rs_haz, rt_haz;
  logic [3:0] rs_res, rt_res;

  function automatic logic [1:0] dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Result packing: {hazard, late, sel[1:0]}; youngest stage wins.
  function automatic logic [3:0] resolve(
    input logic       vld,
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic       ev,
    input logic [4:0] ea,
    input logic [1:0] et,
    input logic       mv,
    input logic [4:0] ma,
    input logic [1:0] mt,
    input logic       wv,
    input logic [4:0] wa,
    input logic [1:0] wt
  );
    logic       hit;
    logic       haz;
    logic [1:0] code;
    logic [1:0] t;
    hit  = 1'b0;
    code = 2'd0;
    t    = 2'd0;
    if (vld && (r != 5'd0) && (tuse != 2'd3)) begin
      if (ev && (ea == r)) begin
        hit  = 1'b1;
        code = 2'd1;
        t    = et;
      end else if (mv && (ma == r)) begin
        hit  = 1'b1;
        code = 2'd2;
        t    = mt;
      end else if (wv && (wa == r)) begin
        hit  = 1'b1;
        code = 2'd3;
        t    = wt;
      end
    end
    haz = hit && (t > tuse);
    return {haz,
            hit && (t != 2'd0) && !haz,
            (hit && (t == 2'd0)) ? code : 2'd0};
  endfunction

  always_comb begin
    rs_res = resolve(d_valid, d_rs, d_rs_tuse,
                     e_v, e_a, e_t, m_v, m_a, m_t, w_v, w_a, w_t);
    rt_res = resolve(d_valid, d_rt, d_rt_tuse,
                     e_v, e_a, e_t, m_v, m_a, m_t, w_v, w_a, w_t);
  end

  assign rs_haz     = rs_res[3];
  assign rt_haz     = rt_res[3];
  assign rs_late    = rs_res[2];
  assign rt_late    = rt_res[2];
  assign rs_fwd_sel = rs_res[1:0];
  assign rt_fwd_sel = rt_res[1:0];
  assign stall      = d_valid & (rs_haz | rt_haz | (d_md_use & md_busy));

  // Stalls only bubble E; M and W keep draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_v <= 1'b0;
      e_a <= 5'd0;
      e_t <= 2'd0;
      m_v <= 1'b0;
      m_a <= 5'd0;
      m_t <= 2'd0;
      w_v <= 1'b0;
      w_a <= 5'd0;
      w_t <= 2'd0;
    end else begin
      w_v <= m_v;
      w_a <= m_a;
      w_t <= dec(m_t);
      m_v <= e_v;
      m_a <= e_a;
      m_t <= dec(e_t);
      if (stall) begin
        e_v <= 1'b0;
        e_a <= 5'd0;
        e_t <= 2'd0;
      end else begin
        e_v <= d_valid & d_wr_en & (d_wr_addr != 5'd0);
        e_a <= d_wr_addr;
        e_t <= d_tnew;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed table-driven bench for grf_hazard_ctrl plus multi-cycle
// sequences for reset, mult/div stalls and counter saturation.
module tb_grf_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_wr_en;
  logic [4:0] d_wr_addr;
  logic [1:0] d_tnew;
  logic       d_md_use;
  logic       md_busy;
  logic       stall;
  logic [1:0] rs_fwd_sel;
  logic [1:0] rt_fwd_sel;
  logic       rs_late;
  logic       rt_late;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  grf_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .d_valid(d_valid),
    .d_rs(d_rs),
    .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse),
    .d_wr_en(d_wr_en),
    .d_wr_addr(d_wr_addr),
    .d_tnew(d_tnew),
    .d_md_use(d_md_use),
    .md_busy(md_busy),
    .stall(stall),
    .rs_fwd_sel(rs_fwd_sel),
    .rt_fwd_sel(rt_fwd_sel),
    .rs_late(rs_late),
    .rt_late(rt_late),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [1:0] rsu;
    logic [4:0] rt;
    logic [1:0] rtu;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       mu;
    logic       mb;
    logic       x_st;
    logic [1:0] x_rss;
    logic [1:0] x_rts;
    logic       x_rsl;
    logic       x_rtl;
    logic [3:0] x_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    int v, int rs, int rsu, int rt, int rtu,
    int we, int wa, int tn, int mu, int mb,
    int st, int rss, int rts, int rsl, int rtl, int cnt
  );
    vec_t x;
    x.v     = 1'(v);
    x.rs    = 5'(rs);
    x.rsu   = 2'(rsu);
    x.rt    = 5'(rt);
    x.rtu   = 2'(rtu);
    x.we    = 1'(we);
    x.wa    = 5'(wa);
    x.tn    = 2'(tn);
    x.mu    = 1'(mu);
    x.mb    = 1'(mb);
    x.x_st  = 1'(st);
    x.x_rss = 2'(rss);
    x.x_rts = 2'(rts);
    x.x_rsl = 1'(rsl);
    x.x_rtl = 1'(rtl);
    x.x_cnt = 4'(cnt);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    d_valid   = x.v;
    d_rs      = x.rs;
    d_rs_tuse = x.rsu;
    d_rt      = x.rt;
    d_rt_tuse = x.rtu;
    d_wr_en   = x.we;
    d_wr_addr = x.wa;
    d_tnew    = x.tn;
    d_md_use  = x.mu;
    md_busy   = x.mb;
  endtask

  task automatic chk_all(input string p, input vec_t x);
    chk({p, ".stall"}, 16'(stall), 16'(x.x_st));
    chk({p, ".rs_sel"}, 16'(rs_fwd_sel), 16'(x.x_rss));
    chk({p, ".rt_sel"}, 16'(rt_fwd_sel), 16'(x.x_rts));
    chk({p, ".rs_late"}, 16'(rs_late), 16'(x.x_rsl));
    chk({p, ".rt_late"}, 16'(rt_late), 16'(x.x_rtl));
    chk({p, ".cnt"}, 16'(stall_cnt), 16'(x.x_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk_all("reset", mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;

    // ALU to branch, E stage
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // load-use, tuse 1
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2));
    // load-use, tuse 0
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 9, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 9, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 9, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 4));
    // $0 writer and reader
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    // priority between stages holding $3
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 3, 0, 0, 3, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 4));
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4));
    // late from E; stalled writer must not enter E
    tbl.push_back(mk(1, 0, 3, 0, 3, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 7, 2, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(1, 7, 0, 0, 3, 1, 10, 0, 0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 10, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 5));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk_all($sformatf("v%0d", i), tbl[i]);
      @(posedge clk);
      #1;
    end

    // mult/div busy for 4 cycles: 4 stalls, 4 bubbles
    do_reset();
    drive(mk(1, 0, 3, 0, 3, 1, 12, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("md%0d.stall", i), 16'(stall), 16'd1);
      @(posedge clk);
      #1;
    end
    drive(mk(1, 12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("md.done.stall", 16'(stall), 16'd0);
    chk("md.bubble.sel", 16'(rs_fwd_sel), 16'd0);
    chk("md.bubble.late", 16'(rs_late), 16'd0);
    chk("md.cnt", 16'(stall_cnt), 16'd4);
    step();

    // hazard and mult/div together: one stall, +1
    drive(mk(1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 5, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    #2;
    chk("both.stall", 16'(stall), 16'd1);
    step();
    chk("both.cnt", 16'(stall_cnt), 16'd5);

    // async reset in the middle of a stall
    do_reset();
    drive(mk(1, 0, 3, 0, 3, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    #1;
    chk("pre.stall", 16'(stall), 16'd1);
    chk("pre.cnt", 16'(stall_cnt), 16'd1);
    reset = 1'b1;
    #1;
    chk("arst.stall", 16'(stall), 16'd0);
    chk("arst.cnt", 16'(stall_cnt), 16'd0);
    chk("arst.rs_sel", 16'(rs_fwd_sel), 16'd0);
    chk("arst.rt_sel", 16'(rt_fwd_sel), 16'd0);
    chk("arst.late", 16'({rs_late, rt_late}), 16'd0);
    step();
    reset = 1'b0;
    #2;
    chk("post.stall", 16'(stall), 16'd0);
    step();

    // saturation at 15
    do_reset();
    drive(mk(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      #2;
      chk($sformatf("sat%0d.cnt", i), 16'(stall_cnt),
          16'((i > 15) ? 15 : i));
      @(posedge clk);
      #1;
    end
    chk("sat.final", 16'(stall_cnt), 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
